// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front-end between the execute stage and a word-indexed data
//   memory. Byte addresses become word indices. Sub-word stores are done as a
//   read-modify-write because the memory only accepts whole-word writes.
//   Loads return sign- or zero-extended data. Misaligned and illegal-size
//   requests complete with an error and never touch memory.
//
//   Ports
//     clk, rst_n                    clock, async active-low reset
//     req_valid / req_ready         request handshake (ready only in IDLE)
//     req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//     resp_valid, resp_err, resp_rdata                      registered response
//     mem_read, mem_write, mem_addr, mem_wdata, mem_rdata   memory port
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a request
//   READ  | memory read (load data, or old word for a sub-word store)
//   WRITE | memory write of the word or the merged word
//   RESP  | one-cycle response pulse

module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t                  state_q, state_d;
   logic                    we_q;
   logic [1:0]              size_q;
   logic                    unsigned_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic                    accept;
   logic                    req_err;
   logic [4:0]              lane_sh;
   logic [DATA_WIDTH-1:0]   rd_shifted;
   logic [DATA_WIDTH-1:0]   load_ext;
   logic [DATA_WIDTH-1:0]   merged;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
         default: req_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_err)                             state_d = RESP;
               else if (req_we && req_size == SZ_WORD)  state_d = WRITE;
               else                                     state_d = READ;
            end
         end
         READ:    state_d = we_q ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
         end
         if (state_q == READ) rdata_q <= mem_rdata;
      end
   end

   // Byte lane offset in bits. Aligned halves have addr_q[0]=0, so the same
   // shift selects the correct half-word lane.
   assign lane_sh    = {addr_q[1:0], 3'b000};
   assign rd_shifted = mem_rdata >> lane_sh;

   always_comb begin
      load_ext = mem_rdata;
      case (size_q)
         SZ_BYTE: load_ext = {{(DATA_WIDTH-8){~unsigned_q & rd_shifted[7]}},
                              rd_shifted[7:0]};
         SZ_HALF: load_ext = {{(DATA_WIDTH-16){~unsigned_q & rd_shifted[15]}},
                              rd_shifted[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      merged = rdata_q;
      case (size_q)
         SZ_BYTE: merged[lane_sh +: 8]  = wdata_q[7:0];
         SZ_HALF: merged[lane_sh +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   assign mem_read  = (state_q == READ);
   assign mem_write = (state_q == WRITE);
   assign mem_addr  = {2'b00, addr_q[ADDR_WIDTH-1:2]};
   assign mem_wdata = merged;

   // Response registers load on the edge that enters RESP. The only direct
   // IDLE->RESP path is the error path; load data is taken straight from
   // memory on the READ->RESP edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= (state_d == RESP);
         resp_err   <= (state_q == IDLE) && (state_d == RESP);
         resp_rdata <= ((state_q == READ) && (state_d == RESP)) ? load_ext : '0;
      end
   end

endmodule
